// File: rtl/add_round_key_stage.sv
// Registered AddRoundKey stage of the iterative AES-128 encrypt datapath.
// Holds the cipher key, expands one round key per accepted beat, and
// presents state ^ round_key on a valid/ready output.
module add_round_key_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         done
);

  localparam int unsigned NR = 10;
  localparam int unsigned W  = 128;
  localparam int unsigned RW = 4;

  // AES S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    rk;
  logic [W-1:0]    rk_next;
  logic [7:0]      rcon;
  logic [RW-1:0]   round;
  logic            accept;
  logic            last_beat;

  // Byte substitution; entry b sits at bit offset 2047-8*b = {~b,3'b111}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  // GF(2^8) multiply by x for the round constant sequence
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Next round key from the current one (AES-128 key expansion step)
  always_comb begin
    logic [31:0] w0, w1, w2, w3, t, rot;
    logic [31:0] n0, n1, n2, n3;
    w0  = rk[127:96];
    w1  = rk[95:64];
    w2  = rk[63:32];
    w3  = rk[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon, 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and input handshake
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last_beat = (round == RW'(NR));
    in_ready  = (state_q == ACTIVE) & ~key_load & (~out_valid | out_ready);
    accept    = in_valid & in_ready;
    if (key_load) begin
      state_d = ACTIVE;
    end else begin
      case (state_q)
        ACTIVE:  if (accept && last_beat) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // Key schedule, round counter and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk        <= '0;
      rcon      <= 8'h01;
      round     <= '0;
      out_valid <= 1'b0;
      out_state <= '0;
      out_round <= '0;
      done      <= 1'b0;
    end else if (key_load) begin
      rk        <= key_in;
      rcon      <= 8'h01;
      round     <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_state <= in_state ^ rk;
      out_round <= round;
      out_valid <= 1'b1;
      round     <= round + RW'(1);
      rk        <= rk_next;
      rcon      <= xtime(rcon);
      if (last_beat) done <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
